// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage plus a carry flop, one bit per clock,
// with a start/busy/done handshake. Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
   logic [WIDTH-1:0] b_load;
   logic             c_q, c_nxt, c_load, s_bit;
   logic [CW-1:0]    cnt_q;
   logic             accept, last;

   // A subtract loads ~b with the carry forced to 1, so the RUN datapath never sees 'sub'.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   assign accept  = start && (state != RUN);
   assign last    = (cnt_q == CW'(WIDTH - 1));
   assign s_bit   = a_q[0] ^ b_q[0] ^ c_q;
   assign c_nxt   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   // Sum bits enter at the MSB and shift right, so after WIDTH steps bit 0 sits at index 0.
   assign acc_nxt = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= 1'b0;
         acc_q <= '0;
         cnt_q <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b_load;
         c_q   <= c_load;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (state == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         c_q   <= c_nxt;
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + CW'(1);
         if (last) begin
            sum  <= acc_nxt;
            cout <= c_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven WIDTH=8 adds, multi-cycle corner
// sequences, and an exhaustive back-to-back run on a WIDTH=1 instance.
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start, start1;
   logic [7:0] a, b;
   logic       cin;
   logic       sub;
   logic [0:0] a1, b1;
   logic       cin1;
   logic       busy, done, cout;
   logic [7:0] sum;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Start one operation on the WIDTH=8 instance and check the full cycle-by-cycle timeline.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                         input logic tsub, input logic [7:0] esum, input logic ecout,
                         input string tag);
      a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("%s busy/done c%0d", tag, c), {30'd0, busy, done}, 32'b10);
         tick();
      end
      check({tag, " done c9"}, {31'd0, done}, 32'd1);
      check({tag, " busy c9"}, {31'd0, busy}, 32'd0);
      check({tag, " sum"},     {24'd0, sum},  {24'd0, esum});
      check({tag, " cout"},    {31'd0, cout}, {31'd0, ecout});
      tick();
      check({tag, " done c10"}, {31'd0, done}, 32'd0);
      check({tag, " sum hold"}, {24'd0, sum},  {24'd0, esum});
   endtask

   initial begin
      vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sum: 8'h8D, cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
      vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
      vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, sum: 8'hFF, cout: 1'b0};
      vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
      vecs[6] = '{a: 8'h01, b: 8'h02, cin: 1'b1, sum: 8'h04, cout: 1'b0};

      rst = 1'b1; start = 1'b0; start1 = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      a1 = '0; b1 = '0; cin1 = 1'b0;
      tick();
      tick();
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset sum",  {24'd0, sum},  32'd0);
      check("reset cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout,
                $sformatf("vec%0d", i));

      // Start pulsed in cycle 4 with new operands, and operands disturbed mid-RUN.
      a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'hC3; b = 8'h7E; cin = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (c == 4) begin
            a = 8'h00; b = 8'hFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         check($sformatf("ign busy c%0d", c), {31'd0, busy}, 32'd1);
         tick();
      end
      start = 1'b0;
      check("ign done c9", {31'd0, done}, 32'd1);
      check("ign sum",     {24'd0, sum},  32'h8D);
      check("ign cout",    {31'd0, cout}, 32'd0);
      for (int c = 10; c <= 20; c++) begin
         tick();
         check($sformatf("ign no 2nd done c%0d", c), {30'd0, busy, done}, 32'd0);
      end

      // Reset asserted in RUN cycle 3 aborts the operation and clears the result.
      a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort busy c3", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort sum",  {24'd0, sum},  32'd0);
      check("abort cout", {31'd0, cout}, 32'd0);
      tick();
      run_op(8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, "post_abort");

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_nb");
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_borrow");
`endif

      // WIDTH=1: all eight {a,b,cin} combinations, each next start issued in the DONE cycle.
      {a1, b1, cin1} = 3'd0;
      start1 = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         start1 = 1'b0;
         check($sformatf("w1 busy %0d", i), {30'd0, busy1, done1}, 32'b10);
         tick();
         check($sformatf("w1 done %0d", i), {30'd0, busy1, done1}, 32'b01);
         check($sformatf("w1 result %0d", i), {30'd0, cout1, sum1},
               32'(v[2]) + 32'(v[1]) + 32'(v[0]));
         if (i < 7) begin
            {a1, b1, cin1} = 3'(i + 1);
            start1 = 1'b1;
         end
         tick();
      end
      check("w1 idle after", {30'd0, busy1, done1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
